// File: rtl/buffer_uart_tx_pkg.sv
// Shared types and constants for the buffer-to-UART transmit path.
package buffer_uart_tx_pkg;

  localparam int unsigned UART_DATA_WIDTH      = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-rate counter: flags the last clock of every UART bit period.
module uart_bit_timer
  import buffer_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_c_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end_c_o = enable_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || bit_end_c_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/buffer_uart_tx.sv
// Pops words from the FIFO buffer and serializes them as UART frames
// (start, LSB-first data, optional even parity, stop) with no gap between frames.
module buffer_uart_tx
  import buffer_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_data,
  input  logic                  buf_valid,
  output logic                  buf_read,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  buf_read_q, buf_read_d;
  logic                  tx_done_q, tx_done_d;
  logic                  timer_clear_c;
  logic                  start_frame_c;
  logic                  bit_end_c;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clear_c),
    .enable_i   (state_q != ST_IDLE),
    .bit_end_c_o(bit_end_c)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    parity_d      = parity_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    buf_read_d    = 1'b0;
    tx_done_d     = 1'b0;
    timer_clear_c = 1'b0;
    start_frame_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d          = 1'b1;
        busy_d        = 1'b0;
        timer_clear_c = 1'b1;
        start_frame_c = buf_valid;
      end
      ST_START: begin
        if (bit_end_c) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            if (PARITY_EN) begin
              tx_d    = parity_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          tx_done_d = 1'b1;
          if (buf_valid) begin
            start_frame_c = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop and latch the next word; shared by idle start and back-to-back start.
    if (start_frame_c) begin
      shift_d       = buf_data;
      parity_d      = ^buf_data;
      buf_read_d    = 1'b1;
      tx_d          = 1'b0;
      busy_d        = 1'b1;
      timer_clear_c = 1'b1;
      state_d       = ST_START;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      buf_read_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      buf_read_q <= buf_read_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign buf_read = buf_read_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Scoreboard bench: two transmitters (parity off / parity on) fed from modelled
// FIFO buffers; a monitor decodes tx cycle by cycle against expected frames.
module tb_buffer_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst_seen = 1'b0;
  logic [7:0] buf_data [2];
  logic [1:0] buf_valid = 2'b00;
  logic [1:0] buf_read;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [1:0] tx_done;

  logic [7:0]  fifo  [2][$];
  logic [15:0] exp_q [2][$];

  bit          active [2];
  int          cnt [2];
  int          flen [2];
  logic [15:0] cur [2];
  int          ferr [2];
  bit          done0 [2];
  int          idle_err [2];
  int          settle [2];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          timeout_flag = 1'b0;
  bit          done_req = 1'b0;
  bit          done_ack = 1'b0;

  buffer_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .buf_data(buf_data[0]), .buf_valid(buf_valid[0]),
    .buf_read(buf_read[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
  );

  buffer_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .buf_data(buf_data[1]), .buf_valid(buf_valid[1]),
    .buf_read(buf_read[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_seen <= rst;

  // Line levels of one frame, index 0 first on the wire.
  function automatic logic [15:0] model_frame(input logic [7:0] w, input bit par);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = w;
    if (par) f[9] = ^w;
    return f;
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, g, $time, got, exp);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      bit ended;
      ended = 1'b0;
      if (!rst_seen) begin
        check("reset_outputs", g, {28'd0, tx[g], busy[g], buf_read[g], tx_done[g]}, 32'h8);
        active[g] = 1'b0;
      end else begin
        if (active[g] && cnt[g] == flen[g]) begin
          check("tx_done_pulse", g, 32'(tx_done[g]), 32'd1);
          check("frame_bad_samples", g, 32'(ferr[g]), 32'd0);
          check("back_to_back", g, 32'(!tx[g]), 32'(buf_valid[g]));
          active[g] = 1'b0;
          ended     = 1'b1;
        end
        if (!active[g]) begin
          if (tx[g] == 1'b0) begin
            check("pop_strobe", g, {30'd0, buf_read[g], buf_valid[g]}, 32'h3);
            check("frame_expected", g, 32'(exp_q[g].size() != 0), 32'd1);
            cur[g] = '1;
            if (exp_q[g].size() != 0) cur[g] = exp_q[g].pop_front();
            flen[g]   = (10 + g) * CPB;
            active[g] = 1'b1;
            cnt[g]    = 0;
            ferr[g]   = 0;
            done0[g]  = ended;
          end else if (busy[g] || buf_read[g] || (tx_done[g] && !ended) || buf_valid[g]) begin
            idle_err[g]++;
          end
        end
        if (active[g]) begin
          if (tx[g] !== cur[g][cnt[g] / CPB]) ferr[g]++;
          if (busy[g] !== 1'b1) ferr[g]++;
          if (buf_read[g] !== (cnt[g] == 0)) ferr[g]++;
          if (tx_done[g] !== (cnt[g] == 0 && done0[g])) ferr[g]++;
          cnt[g]++;
        end
      end

      // Buffer model: data_out/valid settle a few cycles after each pop.
      if (buf_read[g] === 1'b1) begin
        if (fifo[g].size() != 0) fifo[g].delete(0);
        settle[g]    = 2;
        buf_valid[g] = 1'b0;
      end else if (settle[g] > 0) begin
        settle[g]--;
      end else begin
        buf_valid[g] = (fifo[g].size() != 0);
        buf_data[g]  = (fifo[g].size() != 0) ? fifo[g][0] : 8'h00;
      end
    end

    if (done_req && !done_ack) begin
      for (int g = 0; g < 2; g++) begin
        check("scoreboard_empty", g, 32'(exp_q[g].size()), 32'd0);
        check("idle_line_errors", g, 32'(idle_err[g]), 32'd0);
      end
      check("no_timeout", 0, 32'(timeout_flag), 32'd0);
      done_ack = 1'b1;
    end
  end

  task automatic push(input logic [7:0] w);
    for (int g = 0; g < 2; g++) begin
      fifo[g].push_back(w);
      exp_q[g].push_back(model_frame(w, g == 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo[0].size() + fifo[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
           || active[0] || active[1]) begin
      if (n == 20000) begin
        timeout_flag = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    buf_data[0] = 8'h00;
    buf_data[1] = 8'h00;
    // Word waiting while held in reset: no pop until release.
    rst = 1'b0;
    push(8'h96);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drain();

    push(8'hA5);
    drain();
    push(8'h00);
    push(8'hFF);
    drain();
    push(8'h07);
    drain();

    // Reset partway through a frame, then a fresh word.
    push(8'h3C);
    begin
      int n = 0;
      while (tx[0] !== 1'b0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n == 100) timeout_flag = 1'b1;
    end
    repeat (16) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(8'hC3);
    drain();

    repeat (200) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      int nw = int'($urandom_range(1, 3));
      for (int j = 0; j < nw; j++) push(8'($urandom));
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    drain();

    done_req = 1'b1;
    begin
      int n = 0;
      while (!done_ack && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
